// File: rtl/ad9434_spi_master_pkg.sv
// Shared types and constants for the AD9434 3-wire SPI master.
package ad9434_spi_master_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } state_t;

    // Bits driven by the master before SDIO turns around on a read
    localparam int INSTR_W_DEF = 16;
    // AD9434 instruction R/W flag (1 = read), MSB of the frame
    localparam int RW_BIT_POS  = 23;
    localparam int FRAME_W     = 24;

    typedef logic [FRAME_W-1:0] frame_t;

endpackage

// File: rtl/ad9434_spi_master_if.sv
// Command/status bus from the configuration sequencer plus the ADC SPI pins.
interface ad9434_spi_master_if #(
    parameter int MOSI_DATA_WIDTH = 24,
    parameter int MISO_DATA_WIDTH = 8
);
    logic                       i_spi_wr_cmd;
    logic                       i_spi_rd_cmd;
    logic [MOSI_DATA_WIDTH-1:0] i_spi_wr_data;
    logic [MISO_DATA_WIDTH-1:0] o_spi_rd_data;
    logic                       o_spi_busy;
    logic                       o_spi_done;
    logic                       o_sclk;
    logic                       o_csb;
    logic                       o_sdio_o;
    logic                       o_sdio_oe;
    logic                       i_sdio_i;

    // The SPI master block itself
    modport master (
        input  i_spi_wr_cmd, i_spi_rd_cmd, i_spi_wr_data, i_sdio_i,
        output o_spi_rd_data, o_spi_busy, o_spi_done,
        output o_sclk, o_csb, o_sdio_o, o_sdio_oe
    );

    // Sequencer and ADC side
    modport slave (
        output i_spi_wr_cmd, i_spi_rd_cmd, i_spi_wr_data, i_sdio_i,
        input  o_spi_rd_data, o_spi_busy, o_spi_done,
        input  o_sclk, o_csb, o_sdio_o, o_sdio_oe
    );
endinterface

// File: rtl/ad9434_spi_master_sclk_tick.sv
// SCLK phase timer: one full SCLK period is 2*CLK_DIV clks. rise_tick marks the
// last clk of the low half, fall_tick the last clk of the high half.
module ad9434_spi_master_sclk_tick #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic rise_tick,
    output logic fall_tick
);
    localparam int CW = (CLK_DIV > 1) ? $clog2(2 * CLK_DIV) : 1;

    logic [CW-1:0] cnt;

    // Free-running period counter while shifting, parked at zero otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (!en || cnt == CW'(2 * CLK_DIV - 1))
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    assign rise_tick = en && (cnt == CW'(CLK_DIV - 1));
    assign fall_tick = en && (cnt == CW'(2 * CLK_DIV - 1));

endmodule

// File: rtl/ad9434_spi_master.sv
// 3-wire SPI master for the AD9434 serial port. Frames are shifted MSB first on
// SCLK (CPOL=0); reads release SDIO after the instruction and shift the reply in.
module ad9434_spi_master
    import ad9434_spi_master_pkg::*;
#(
    parameter int MOSI_DATA_WIDTH = 24,
    parameter int MISO_DATA_WIDTH = 8,
    parameter int INSTR_WIDTH     = INSTR_W_DEF,
    parameter int CLK_DIV         = 4,
    parameter int CS_SETUP        = 2,
    parameter int CS_HOLD         = 2,
    parameter int CS_GAP          = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    ad9434_spi_master_if.master  bus
);
    state_t                     state, next_state;
    logic [7:0]                 tmr, tmr_d;
    logic [4:0]                 bit_cnt;
    logic                       is_read;
    logic [MOSI_DATA_WIDTH-1:0] sreg;
    logic [MISO_DATA_WIDTH-1:0] rx, rx_d;
    logic                       rise_tick, fall_tick;
    logic                       cmd;
    logic                       last_bit;

    logic                       sclk_q, csb_q, sdo_q, oe_q, busy_q, done_q;
    logic                       sclk_d, csb_d, sdo_d, oe_d, busy_d, done_d;
    logic [MISO_DATA_WIDTH-1:0] rd_q, rd_d;

    assign cmd      = bus.i_spi_wr_cmd | bus.i_spi_rd_cmd;
    assign last_bit = fall_tick && (bit_cnt == 5'(MOSI_DATA_WIDTH - 1));

    ad9434_spi_master_sclk_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (state == SHIFT),
        .rise_tick (rise_tick),
        .fall_tick (fall_tick)
    );

    // State, phase timer, bit counter and all registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            tmr     <= '0;
            bit_cnt <= '0;
            is_read <= 1'b0;
            sclk_q  <= 1'b0;
            csb_q   <= 1'b1;
            sdo_q   <= 1'b0;
            oe_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rd_q    <= '0;
        end else begin
            state   <= next_state;
            tmr     <= tmr_d;
            if (state != SHIFT)
                bit_cnt <= '0;
            else if (fall_tick)
                bit_cnt <= bit_cnt + 5'd1;
            if (state == IDLE && cmd)
                is_read <= bus.i_spi_rd_cmd;
            sclk_q  <= sclk_d;
            csb_q   <= csb_d;
            sdo_q   <= sdo_d;
            oe_q    <= oe_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            rd_q    <= rd_d;
        end
    end

    // Frame sequencing: setup, 24 SCLK periods, hold, inter-frame gap
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (cmd) next_state = SETUP;
            SETUP:   if (tmr == 8'(CS_SETUP - 1)) next_state = SHIFT;
            SHIFT:   if (last_bit) next_state = HOLD;
            HOLD:    if (tmr == 8'(CS_HOLD - 1)) next_state = GAP;
            GAP:     if (tmr == 8'(CS_GAP - 1)) next_state = IDLE;
            default: next_state = IDLE;
        endcase
        tmr_d = (next_state != state) ? 8'd0 : tmr + 8'd1;
    end

    // Next values of the pin and status registers
    always_comb begin
        sclk_d = 1'b0;
        csb_d  = 1'b1;
        sdo_d  = 1'b0;
        oe_d   = 1'b0;
        done_d = 1'b0;
        busy_d = (next_state != IDLE);
        rd_d   = rd_q;
        rx_d   = rx;
        if (state == SHIFT && fall_tick && is_read && bit_cnt >= 5'(INSTR_WIDTH))
            rx_d = {rx[MISO_DATA_WIDTH-2:0], bus.i_sdio_i};
        case (next_state)
            SETUP: begin
                csb_d = 1'b0;
                oe_d  = 1'b1;
                sdo_d = (state == IDLE) ? bus.i_spi_wr_data[MOSI_DATA_WIDTH-1] : sdo_q;
            end
            SHIFT: begin
                csb_d  = 1'b0;
                sclk_d = rise_tick ? 1'b1 : (fall_tick ? 1'b0 : sclk_q);
                sdo_d  = fall_tick ? sreg[MOSI_DATA_WIDTH-2] : sdo_q;
                // Turnaround: release SDIO on the fall that ends the instruction
                oe_d   = (is_read && fall_tick && bit_cnt == 5'(INSTR_WIDTH - 1)) ? 1'b0 : oe_q;
            end
            HOLD: begin
                csb_d  = 1'b0;
                done_d = (tmr_d == 8'(CS_HOLD - 1));
                if (done_d && is_read)
                    rd_d = rx_d;
            end
            default: ;
        endcase
    end

    // Transmit and receive shift registers (data only, no reset needed)
    always_ff @(posedge clk) begin
        if (state == IDLE && cmd)
            sreg <= bus.i_spi_wr_data;
        else if (state == SHIFT && fall_tick)
            sreg <= sreg << 1;
        rx <= rx_d;
    end

    assign bus.o_sclk        = sclk_q;
    assign bus.o_csb         = csb_q;
    assign bus.o_sdio_o      = sdo_q;
    assign bus.o_sdio_oe     = oe_q;
    assign bus.o_spi_busy    = busy_q;
    assign bus.o_spi_done    = done_q;
    assign bus.o_spi_rd_data = rd_q;

endmodule
